// File: rtl/construct_data_if.sv
// Stream bundle for construct_data: narrow pixel input side and wide packed-word output side.
//   ivalid/idata/iready : pixel stream into the packer
//   ovalid/oready       : packed-word handshake toward the write-data FIFO
//   odata/omask/olast   : packed word, byte-valid mask (bit ISIZE/8-1 = MSB byte), flush marker
// slave modport is the packer, master modport is the surrounding logic.
interface construct_data_if #(
   parameter int unsigned ISIZE = 256,
   parameter int unsigned OSIZE = 24
);
   logic                 ivalid;
   logic [OSIZE-1:0]     idata;
   logic                 iready;
   logic                 ovalid;
   logic                 oready;
   logic [ISIZE-1:0]     odata;
   logic [ISIZE/8-1:0]   omask;
   logic                 olast;

   modport slave (
      input  ivalid, idata, oready,
      output iready, ovalid, odata, omask, olast
   );

   modport master (
      output ivalid, idata, oready,
      input  iready, ovalid, odata, omask, olast
   );
endinterface

// File: rtl/construct_data.sv
// Packs OSIZE-bit pixels MSB-first, bit-continuously, into ISIZE-bit bus words.
// Ports:
//   clock  : rising-edge clock
//   rst    : synchronous active-high reset
//   ialign : drop the partial word, restart packing at bit ISIZE-1
//   flush  : emit the pending partial word zero-padded with olast=1
//   bus    : construct_data_if.slave (pixel in, packed word out)
// iready is combinational: a full word leaving the accumulator frees room for the
// pixel accepted in the same cycle, so the stream runs without bubbles.
module construct_data #(
   parameter int unsigned ISIZE = 256,
   parameter int unsigned OSIZE = 24
) (
   input  logic            clock,
   input  logic            rst,
   input  logic            ialign,
   input  logic            flush,
   construct_data_if.slave bus
);

   localparam int unsigned AW = ISIZE + OSIZE;
   localparam int unsigned FW = $clog2(AW + 1);
   localparam int unsigned NB = ISIZE / 8;

   logic [AW-1:0]    acc_q, acc_d;
   logic [FW-1:0]    fill_q, fill_d;
   logic             flush_pend_q, flush_pend_d;
   logic             ovalid_q, ovalid_d;
   logic [ISIZE-1:0] odata_q, odata_d;
   logic [NB-1:0]    omask_q, omask_d;
   logic             olast_q, olast_d;

   logic             slot_free;
   logic             full;
   logic             move;
   logic             emit;
   logic             iready;
   logic             accept;
   logic [FW-1:0]    fill_mv;
   logic [FW-1:0]    nbytes;
   logic [ISIZE-1:0] pad_keep;

   // Next-state: drain full words, insert pixels, flush partial word, realign
   always_comb begin
      acc_d        = acc_q;
      fill_d       = fill_q;
      flush_pend_d = flush_pend_q;
      ovalid_d     = ovalid_q;
      odata_d      = odata_q;
      omask_d      = omask_q;
      olast_d      = olast_q;

      slot_free = !ovalid_q || bus.oready;
      full      = fill_q >= FW'(ISIZE);
      move      = full && slot_free && !ialign;
      emit      = flush_pend_q && !full && (fill_q != '0) && slot_free && !ialign;
      iready    = !rst && !ialign && !flush_pend_q && (!full || move);
      accept    = bus.ivalid && iready;
      fill_mv   = move ? fill_q - FW'(ISIZE) : fill_q;
      nbytes    = (fill_q + FW'(7)) >> 3;
      pad_keep  = ~({ISIZE{1'b1}} >> fill_q);

      if (bus.oready) begin
         ovalid_d = 1'b0;
      end

      if (move) begin
         ovalid_d = 1'b1;
         odata_d  = acc_q[AW-1 -: ISIZE];
         omask_d  = '1;
         olast_d  = flush_pend_q && (fill_q == FW'(ISIZE));
         acc_d    = acc_q << ISIZE;
         if (flush_pend_q && (fill_q == FW'(ISIZE))) begin
            flush_pend_d = 1'b0;
         end
      end

      // Bits below fill are always zero, so OR-insertion is safe
      if (accept) begin
         acc_d  = acc_d | ({bus.idata, {ISIZE{1'b0}}} >> fill_mv);
         fill_d = fill_mv + FW'(OSIZE);
      end else begin
         fill_d = fill_mv;
      end

      if (emit) begin
         ovalid_d     = 1'b1;
         odata_d      = acc_q[AW-1 -: ISIZE] & pad_keep;
         omask_d      = ~({NB{1'b1}} >> nbytes);
         olast_d      = 1'b1;
         acc_d        = '0;
         fill_d       = '0;
         flush_pend_d = 1'b0;
      end

      // Nothing left to flush: retire the request silently
      if (flush_pend_q && (fill_q == '0)) begin
         flush_pend_d = 1'b0;
      end

      if (flush) begin
         flush_pend_d = 1'b1;
      end

      // Realign wins over flush and input; the output register is untouched
      if (ialign) begin
         acc_d        = '0;
         fill_d       = '0;
         flush_pend_d = 1'b0;
      end
   end

   // State registers
   always_ff @(posedge clock) begin
      if (rst) begin
         acc_q        <= '0;
         fill_q       <= '0;
         flush_pend_q <= 1'b0;
         ovalid_q     <= 1'b0;
         odata_q      <= '0;
         omask_q      <= '0;
         olast_q      <= 1'b0;
      end else begin
         acc_q        <= acc_d;
         fill_q       <= fill_d;
         flush_pend_q <= flush_pend_d;
         ovalid_q     <= ovalid_d;
         odata_q      <= odata_d;
         omask_q      <= omask_d;
         olast_q      <= olast_d;
      end
   end

   assign bus.iready = iready;
   assign bus.ovalid = ovalid_q;
   assign bus.odata  = odata_q;
   assign bus.omask  = omask_q;
   assign bus.olast  = olast_q;

endmodule
